// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit WISC CPU.
//   INSTR_W / PC_W : instruction word and PC widths
//   OPC_HLT        : opcode field value of the HLT instruction
//   RESET_PC       : PC value loaded by reset
//   INSTR_BYTES    : byte distance between consecutive instructions
//   fetch_state_e  : fetch stage FSM states
//   pc_add         : modulo-2^16 PC increment helper
package cpu_pkg;

    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned PC_W        = 16;
    localparam logic [3:0]  OPC_HLT     = 4'hF;
    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam int unsigned INSTR_BYTES = 2;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // PC arithmetic wraps silently at 2^16; there is no carry out.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] base,
                                               input logic [PC_W-1:0] step);
        return base + step;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register with its next-PC mux.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : take load_pc (redirect), highest priority
//   load_pc     : redirect target, used exactly as given (odd values included)
//   advance     : step past base_pc (a fetch response was consumed)
//   base_pc     : address of the instruction just returned
//   fetch_pc    : address of the next instruction to request
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VAL = RESET_PC,
    parameter int unsigned     STEP      = INSTR_BYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            advance,
    input  logic [PC_W-1:0] base_pc,
    output logic [PC_W-1:0] fetch_pc
);

    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    logic [PC_W-1:0] fetch_pc_next;

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (load) begin
            fetch_pc_next = load_pc;
        end else if (advance) begin
            fetch_pc_next = pc_add(base_pc, STEP_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_VAL;
        end else begin
            fetch_pc <= fetch_pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 16-bit WISC CPU.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_req       : read request, held until imem_valid
//   imem_addr      : read address, stable while a request is in flight
//   imem_rdata     : returned instruction word
//   imem_valid     : imem_rdata valid this cycle (may coincide with the request)
//   stall          : downstream not ready; output register holds
//   redirect       : taken branch from execute; squashes output and in-flight fetch
//   redirect_pc    : new fetch PC when redirect=1
//   instr, pc      : registered instruction and its address
//   pc_plus2       : pc + INSTR_BYTES
//   instr_valid    : instr/pc valid
//   fetch_halted   : sticky, set once a HLT is accepted downstream
//
// Handshake: the output pair transfers on a cycle where instr_valid=1 and
// stall=0 ("accept"). A memory transfer happens on a cycle where imem_req=1
// and imem_valid=1; once raised, imem_req and imem_addr stay put until then.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC_P  = RESET_PC,
    parameter logic [3:0]      HALT_OPCODE = OPC_HLT,
    parameter int unsigned     STEP        = INSTR_BYTES
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus2,
    output logic               fetch_halted
);

    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    fetch_state_e state, state_next;

    logic            busy, busy_next;       // request in flight
    logic            drop, drop_next;       // in-flight response is stale
    logic [PC_W-1:0] req_addr, req_addr_next;

    // One-entry holding slot: a response from a request issued before a
    // stall began can arrive while the output register is still occupied.
    logic               pend_valid, pend_valid_next;
    logic [INSTR_W-1:0] pend_instr, pend_instr_next;
    logic [PC_W-1:0]    pend_pc, pend_pc_next;

    logic [INSTR_W-1:0] instr_next;
    logic               instr_valid_next;
    logic [PC_W-1:0]    pc_next, pc_plus2_next;
    logic               halted_next;

    logic            pc_load, pc_advance;
    logic [PC_W-1:0] fetch_pc;

    logic accept, in_fetch, resp, out_free, hlt_accept;

    fetch_pc_reg #(
        .RESET_VAL (RESET_PC_P),
        .STEP      (STEP)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_pc  (redirect_pc),
        .advance  (pc_advance),
        .base_pc  (imem_addr),
        .fetch_pc (fetch_pc)
    );

    assign accept   = instr_valid && !stall;
    assign in_fetch = (state == FETCH);
    assign out_free = !instr_valid || accept;

    // rst_n gates the request so nothing is issued while reset is held.
    assign imem_req = rst_n && in_fetch &&
                      (redirect || (!pend_valid && (busy || !instr_valid || accept)));

    // An in-flight request keeps its address even across a redirect; with
    // nothing in flight a redirect is issued to redirect_pc straight away.
    assign imem_addr = busy     ? req_addr    :
                       redirect ? redirect_pc : fetch_pc;

    assign resp       = imem_req && imem_valid;
    assign hlt_accept = in_fetch && accept && !redirect &&
                        (instr[INSTR_W-1:INSTR_W-4] == HALT_OPCODE);

    always_comb begin
        state_next       = state;
        busy_next        = busy;
        drop_next        = drop;
        req_addr_next    = req_addr;
        pend_valid_next  = pend_valid;
        pend_instr_next  = pend_instr;
        pend_pc_next     = pend_pc;
        instr_next       = instr;
        instr_valid_next = instr_valid;
        pc_next          = pc;
        pc_plus2_next    = pc_plus2;
        halted_next      = fetch_halted;
        pc_load          = 1'b0;
        pc_advance       = 1'b0;

        if (in_fetch) begin
            if (redirect) begin
                instr_valid_next = 1'b0;
                pend_valid_next  = 1'b0;
                pc_load          = 1'b1;
                if (busy && !imem_valid) begin
                    // Let the stale request finish, then discard it.
                    drop_next = 1'b1;
                end else if (!busy && !imem_valid) begin
                    busy_next     = 1'b1;
                    drop_next     = 1'b0;
                    req_addr_next = redirect_pc;
                end else begin
                    // Coinciding response is discarded.
                    busy_next = 1'b0;
                    drop_next = 1'b0;
                end
            end else if (hlt_accept) begin
                state_next       = HALTED;
                halted_next      = 1'b1;
                instr_valid_next = 1'b0;
                busy_next        = 1'b0;
                drop_next        = 1'b0;
                pend_valid_next  = 1'b0;
            end else begin
                if (resp) begin
                    busy_next = 1'b0;
                    if (drop) begin
                        drop_next = 1'b0;
                        if (accept) begin
                            instr_valid_next = 1'b0;
                        end
                    end else begin
                        pc_advance = 1'b1;
                        if (out_free) begin
                            instr_next       = imem_rdata;
                            pc_next          = imem_addr;
                            pc_plus2_next    = pc_add(imem_addr, STEP_V);
                            instr_valid_next = 1'b1;
                        end else begin
                            pend_valid_next = 1'b1;
                            pend_instr_next = imem_rdata;
                            pend_pc_next    = imem_addr;
                        end
                    end
                end else begin
                    if (imem_req && !busy) begin
                        busy_next     = 1'b1;
                        req_addr_next = imem_addr;
                    end
                    if (pend_valid && out_free) begin
                        instr_next       = pend_instr;
                        pc_next          = pend_pc;
                        pc_plus2_next    = pc_add(pend_pc, STEP_V);
                        instr_valid_next = 1'b1;
                        pend_valid_next  = 1'b0;
                    end else if (accept) begin
                        instr_valid_next = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            drop         <= 1'b0;
            req_addr     <= RESET_PC_P;
            pend_valid   <= 1'b0;
            pend_instr   <= '0;
            pend_pc      <= RESET_PC_P;
            instr        <= '0;
            instr_valid  <= 1'b0;
            pc           <= RESET_PC_P;
            pc_plus2     <= pc_add(RESET_PC_P, STEP_V);
            fetch_halted <= 1'b0;
        end else begin
            busy         <= busy_next;
            drop         <= drop_next;
            req_addr     <= req_addr_next;
            pend_valid   <= pend_valid_next;
            pend_instr   <= pend_instr_next;
            pend_pc      <= pend_pc_next;
            instr        <= instr_next;
            instr_valid  <= instr_valid_next;
            pc           <= pc_next;
            pc_plus2     <= pc_plus2_next;
            fetch_halted <= halted_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory of
// programmable latency (1 = zero-wait).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fetch_halted;

    int passed = 0;
    int total  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mem [0:255];
    int          mem_lat;
    int          lat_cnt;

    always_ff @(posedge clk) begin
        if (imem_req && !imem_valid) begin
            lat_cnt <= lat_cnt + 1;
        end else begin
            lat_cnt <= 0;
        end
    end

    assign imem_valid = imem_req && (lat_cnt == mem_lat - 1);
    assign imem_rdata = mem[imem_addr[8:1]];

    // ---------------- DUT ----------------
    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .fetch_halted (fetch_halted)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] p,
                             input logic [15:0] p2, input logic [15:0] ins);
        check({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, v});
        check({tag, ".pc"}, pc, p);
        check({tag, ".pc_plus2"}, pc_plus2, p2);
        check({tag, ".instr"}, instr, ins);
    endtask

    task automatic check_reset(input string tag);
        check_out(tag, 1'b0, 16'h0000, 16'h0002, 16'h0000);
        check({tag, ".halted"}, {15'd0, fetch_halted}, 16'd0);
        check({tag, ".req"}, {15'd0, imem_req}, 16'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0]   = 16'h1111;  // 0x0000
        mem[1]   = 16'h2222;  // 0x0002
        mem[2]   = 16'h3333;  // 0x0004
        mem[3]   = 16'h4444;  // 0x0006
        mem[4]   = 16'hF000;  // 0x0008 HLT
        mem[32]  = 16'h5555;  // 0x0040
        mem[33]  = 16'h6666;  // 0x0042
        mem[255] = 16'h7777;  // 0xFFFE

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        mem_lat = 1;
        repeat (2) @(posedge clk);
        #2;
        check_reset("reset");

        // zero-wait streaming
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check_out("zw0", 1'b1, 16'h0000, 16'h0002, 16'h1111);
        tick(); check_out("zw1", 1'b1, 16'h0002, 16'h0004, 16'h2222);

        // stall holds the output and issues nothing
        stall = 1'b1;
        #1 check("stall.req", {15'd0, imem_req}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("stall_hold", 1'b1, 16'h0002, 16'h0004, 16'h2222);
            check("stall_hold.req", {15'd0, imem_req}, 16'd0);
        end
        stall = 1'b0;
        #1 check("unstall.addr", imem_addr, 16'h0004);
        check("unstall.req", {15'd0, imem_req}, 16'd1);
        tick(); check_out("zw2", 1'b1, 16'h0004, 16'h0006, 16'h3333);

        // 3-cycle memory, redirect while fetch of 0x0006 is in flight
        mem_lat = 3;
        #1 check("lat.addr0", imem_addr, 16'h0006);
        tick(); check("lat.valid1", {15'd0, instr_valid}, 16'd0);
        check("lat.addr1", imem_addr, 16'h0006);
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1 check("redir.addr_held", imem_addr, 16'h0006);
        tick(); check("redir.valid", {15'd0, instr_valid}, 16'd0);
        redirect = 1'b0;
        #1 check("stale.addr", imem_addr, 16'h0006);
        check("stale.req", {15'd0, imem_req}, 16'd1);
        tick(); check("drop.valid", {15'd0, instr_valid}, 16'd0);
        #1 check("resume.addr", imem_addr, 16'h0040);
        tick(); check("w40a.valid", {15'd0, instr_valid}, 16'd0);
        check("w40a.addr", imem_addr, 16'h0040);
        tick(); check("w40b.valid", {15'd0, instr_valid}, 16'd0);
        check("w40b.addr", imem_addr, 16'h0040);
        tick(); check_out("lat40", 1'b1, 16'h0040, 16'h0042, 16'h5555);
        #1 check("lat42.addr", imem_addr, 16'h0042);
        tick(); check("w42a.valid", {15'd0, instr_valid}, 16'd0);
        tick(); check("w42b.valid", {15'd0, instr_valid}, 16'd0);
        tick(); check_out("lat42", 1'b1, 16'h0042, 16'h0044, 16'h6666);

        // zero-wait redirect to the HLT word
        mem_lat = 1;
        redirect = 1'b1; redirect_pc = 16'h0008;
        #1 check("r8.addr", imem_addr, 16'h0008);
        tick(); check("r8.valid", {15'd0, instr_valid}, 16'd0);
        redirect = 1'b0;
        tick(); check_out("hlt_fetched", 1'b1, 16'h0008, 16'h000A, 16'hF000);
        check("hlt_fetched.halted", {15'd0, fetch_halted}, 16'd0);

        // redirect in the acceptance cycle squashes the HLT; wrap at 0xFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick(); check("squash.halted", {15'd0, fetch_halted}, 16'd0);
        check("squash.valid", {15'd0, instr_valid}, 16'd0);
        redirect = 1'b0;
        tick(); check_out("wrap", 1'b1, 16'hFFFE, 16'h0000, 16'h7777);
        #1 check("wrap.next_addr", imem_addr, 16'h0000);
        tick(); check_out("wrap_next", 1'b1, 16'h0000, 16'h0002, 16'h1111);

        // HLT accepted for real
        redirect = 1'b1; redirect_pc = 16'h0008;
        tick(); redirect = 1'b0;
        tick(); check_out("hlt2_fetched", 1'b1, 16'h0008, 16'h000A, 16'hF000);
        tick(); check("halt.halted", {15'd0, fetch_halted}, 16'd1);
        check("halt.valid", {15'd0, instr_valid}, 16'd0);
        #1 check("halt.req", {15'd0, imem_req}, 16'd0);
        redirect = 1'b1; redirect_pc = 16'h0040;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halted.halted", {15'd0, fetch_halted}, 16'd1);
            check("halted.valid", {15'd0, instr_valid}, 16'd0);
            check("halted.req", {15'd0, imem_req}, 16'd0);
            check("halted.pc", pc, 16'h0008);
        end
        redirect = 1'b0;

        // reset leaves HALTED
        rst_n = 1'b0;
        #1 check_reset("reset_halted");

        // reset in the middle of a 3-cycle fetch
        mem_lat = 3;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid.req0", {15'd0, imem_req}, 16'd1);
        tick(); check("mid.req1", {15'd0, imem_req}, 16'd1);
        check("mid.addr", imem_addr, 16'h0000);
        check("mid.valid", {15'd0, instr_valid}, 16'd0);
        #3 rst_n = 1'b0;
        #1 check_reset("reset_mid");

        mem_lat = 1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check_out("restart", 1'b1, 16'h0000, 16'h0002, 16'h1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
